// File: rtl/store_merge_rmw.sv
// Sub-word store unit: SW writes directly, SB/SH do read-merge-write.
// Holds busy high for the whole transaction to stall the pipeline.
module store_merge_rmw (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;
   localparam logic [1:0] OP_RS = 2'd3;

   logic [2:0]  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merged_q, merged_d;

   logic        bad_req;
   logic [31:0] merged;

   assign bad_req = (req_op == OP_RS)
                  | ((req_op == OP_SW) & (req_addr[1:0] != 2'b00))
                  | ((req_op == OP_SH) & req_addr[0]);

   // Unselected lanes pass through bit-identical from the read word.
   always_comb begin
      merged = mem_rdata;
      if (op_q == OP_SB)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (op_q == OP_SH)
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      merged_d = merged_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (bad_req)
                  state_d = S_ERR;
               else if (req_op == OP_SW)
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            merged_d = merged;
            state_d  = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         merged_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merged_q <= merged_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_WRITE) | (state_q == S_ERR);
   assign err       = (state_q == S_ERR);
   assign mem_rd_en = (state_q == S_READ);
   assign mem_wr_en = (state_q == S_WRITE);
   assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata = (state_q != S_WRITE) ? 32'h0
                    : (op_q == OP_SW) ? wdata_q : merged_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed bench for store_merge_rmw with a one-word synchronous memory model.
module tb_store_merge_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy, done, err;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   logic [31:0] mem_word;
   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int rd_cnt  = 0;
   int wr_base, rd_base;

   always #5 clk = ~clk;

   store_merge_rmw dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .err(err),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata)
   );

   // Read data valid exactly one cycle after the strobe; junk otherwise.
   always @(posedge clk) begin
      mem_rdata <= mem_rd_en ? mem_word : 32'hA5A5_A5A5;
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = d;
      wr_base   = wr_cnt;
      rd_base   = rd_cnt;
   endtask

   task automatic drop_and_idle(input string tag);
      req_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_idle_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_idle_addr"}, mem_addr, 32'h0);
   endtask

   task automatic run_sw(input string tag, input logic [31:0] a,
                         input logic [31:0] d);
      issue(2'd0, a, d);
      @(negedge clk);
      chk({tag, "_wr"},   {31'h0, mem_wr_en}, 32'h1);
      chk({tag, "_rd"},   {31'h0, mem_rd_en}, 32'h0);
      chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_data"}, mem_wdata, d);
      chk({tag, "_done"}, {30'h0, done, err}, 32'h2);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
   endtask

   task automatic run_rmw(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
      issue(op, a, d);
      @(negedge clk);
      chk({tag, "_t1_rd"},   {30'h0, mem_rd_en, mem_wr_en}, 32'h2);
      chk({tag, "_t1_bd"},   {30'h0, busy, done}, 32'h2);
      chk({tag, "_t1_addr"}, mem_addr, {a[31:2], 2'b00});
      @(negedge clk);
      chk({tag, "_t2"}, {28'h0, busy, done, mem_rd_en, mem_wr_en}, 32'h8);
      @(negedge clk);
      chk({tag, "_t3_wr"},   {30'h0, mem_rd_en, mem_wr_en}, 32'h1);
      chk({tag, "_t3_de"},   {29'h0, busy, done, err}, 32'h6);
      chk({tag, "_t3_data"}, mem_wdata, exp);
   endtask

   task automatic run_err(input string tag, input logic [1:0] op,
                          input logic [31:0] a);
      issue(op, a, 32'h1234_5678);
      @(negedge clk);
      chk({tag, "_de"},  {29'h0, busy, done, err}, 32'h7);
      chk({tag, "_mem"}, {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
      drop_and_idle(tag);
      chk({tag, "_nowr"}, wr_cnt - wr_base, 32'h0);
      chk({tag, "_nord"}, rd_cnt - rd_base, 32'h0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_word  = 32'h1122_3344;
      repeat (2) @(negedge clk);
      chk("rst_flags", {27'h0, busy, done, err, mem_rd_en, mem_wr_en}, 32'h0);
      chk("rst_addr",  mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst = 1'b0;

      run_sw("sw10", 32'h0000_0010, 32'hDEAD_BEEF);
      drop_and_idle("sw10");
      chk("sw10_cnt", wr_cnt - wr_base, 32'h1);
      chk("sw10_nord", rd_cnt - rd_base, 32'h0);

      run_rmw("sb22", 2'd2, 32'h0000_0022, 32'h0000_00AB, 32'h11AB_3344);
      drop_and_idle("sb22");
      chk("sb22_cnt", wr_cnt - wr_base, 32'h1);

      run_rmw("sb21", 2'd2, 32'h0000_0021, 32'hFFFF_FF5A, 32'h1122_5A44);
      drop_and_idle("sb21");

      run_rmw("sh42", 2'd1, 32'h0000_0042, 32'hFFFF_CAFE, 32'hCAFE_3344);
      drop_and_idle("sh42");

      run_rmw("sh40", 2'd1, 32'h0000_0040, 32'hFFFF_CAFE, 32'h1122_CAFE);
      drop_and_idle("sh40");

      run_err("sh41", 2'd1, 32'h0000_0041);
      run_err("sw02", 2'd0, 32'h0000_0002);
      run_err("op3",  2'd3, 32'h0000_0000);

      // Reset while waiting for read data must suppress the write.
      issue(2'd2, 32'h0000_0030, 32'h0000_0077);
      @(negedge clk);
      @(negedge clk);
      chk("rstw_inwait", {31'h0, busy}, 32'h1);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstw_idle", {28'h0, busy, done, mem_rd_en, mem_wr_en}, 32'h0);
      chk("rstw_addr", mem_addr, 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstw_nowr", wr_cnt - wr_base, 32'h0);
      run_sw("rstw_sw", 32'h0000_0034, 32'h0BAD_F00D);
      drop_and_idle("rstw_sw");
      chk("rstw_sw_cnt", wr_cnt - wr_base, 32'h1);

      // SB then SW with req_valid left high: SW taken in the cycle after done.
      mem_word = 32'hA0B1_C2D3;
      run_rmw("b2b_sb", 2'd2, 32'h0000_0103, 32'h0000_00EE, 32'hEEB1_C2D3);
      wr_base   = wr_cnt;
      req_op    = 2'd0;
      req_addr  = 32'h0000_0200;
      req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("b2b_gap", {29'h0, busy, done, mem_wr_en}, 32'h0);
      @(negedge clk);
      chk("b2b_sw_wr",   {31'h0, mem_wr_en}, 32'h1);
      chk("b2b_sw_addr", mem_addr, 32'h0000_0200);
      chk("b2b_sw_data", mem_wdata, 32'h5555_AAAA);
      chk("b2b_sw_de",   {30'h0, done, err}, 32'h2);
      drop_and_idle("b2b");
      chk("b2b_cnt", wr_cnt - wr_base, 32'h2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
